tabla_scanner: RTL and testbench
================================

# tabla_scanner

Sequential stimulus-and-capture stage placed directly upstream of the lab 5 table multiplexers (2:1, 4:1 and 8:1 table implementations). It drives the A/B/C select inputs through all eight combinations and waits a programmable settle time at each one. It samples the mux output Y back and assembles the observed 8-entry truth table. The captured table is compared against a golden value and reported through a start/busy/done handshake.

## Interface
Parameters:
- SETTLE, default 2: cycles a combination is held before sampling; legal range 1..15.
- EXPECTED, default 8'h96: golden truth table; bit i = Y for {A,B,C} = i (A is MSB). 8'h96 encodes 0,1,1,0,1,0,0,1 for i = 0..7.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
- continuous  input  1  when 1, a new scan starts automatically after DONE.
- y_in  input  1  Y output of the mux under test.
- a_out, b_out, c_out  output  1 each  select/data drive to the mux under test; {a_out,b_out,c_out} = current index.
- busy  output  1  high in WAIT and SAMPLE.
- done  output  1  one-cycle pulse in DONE.
- table_out  output  8  last completed truth table.
- match  output  1  (table_out == EXPECTED), updated with table_out.
- mismatch_count  output  4  popcount(table_out ^ EXPECTED), 0..8.
- first_fail  output  3  lowest index with a mismatch; 0 if none.

## Operation
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE: selects = 3'b000. If start = 1: idx <= 0, settle counter <= 0, working table <= 0, go to WAIT.
- WAIT: selects = idx. The counter increments each cycle. After SETTLE cycles in WAIT, go to SAMPLE.
- SAMPLE: selects = idx. At the end of this cycle, working_table[idx] <= y_in. If idx == 7, go to DONE. Otherwise, idx <= idx+1, counter <= 0, go to WAIT.
- DONE: selects = 3'b000 and done = 1. Registered outputs update on exit from DONE, visible the cycle after the done pulse:
  - table_out <= working table
  - match
  - mismatch_count
  - first_fail
- From DONE: if continuous = 1, restart as from IDLE with start. Otherwise, go to IDLE.
- start is ignored in every state except IDLE; no queuing.
- Index wrap: idx never exceeds 7; 7 always exits to DONE.
- Results hold their value until the next DONE; a scan in progress does not disturb them.

## Timing
- Reset values:
  - state = IDLE, idx = 0, selects = 0
  - busy = 0, done = 0
  - table_out = 8'h00, match = 0, mismatch_count = 0, first_fail = 0
- Reset mid-scan: abandon the scan, return to reset values the next cycle, and discard partial results.
- start high at edge t0 (in IDLE): busy = 1 from t0+1.
- Index k is driven during cycles t0+1+k(SETTLE+1) through t0+(k+1)(SETTLE+1).
- done pulses at t0+1+8(SETTLE+1), which is t0+25 for SETTLE = 2. Results are valid from the following cycle.
- Scan period in continuous mode: 8(SETTLE+1)+1 cycles.
- Reset and start in the same cycle: reset wins.

## Configuration
- TABLA_MISMATCH_EN defined: mismatch_count and first_fail are computed and registered as specified.
- TABLA_MISMATCH_EN undefined: the ports remain present but are tied to 0, and no popcount/priority logic is synthesised. match and table_out are unaffected.

## Test plan
- Reset: assert reset 2 cycles → all outputs 0, selects 000, busy 0. Then deassert → outputs stay 0 with no start.
- Correct DUT (y_in = A^B^C), SETTLE = 2, start pulse at t0 → select sequence 000..111, each index held 3 cycles. done at t0+25. Next cycle: table_out = 8'h96, match = 1, mismatch_count = 0, first_fail = 0.
- Stuck-at-0 y_in → table_out = 8'h00, match = 0, mismatch_count = 4, first_fail = 1 (with TABLA_MISMATCH_EN); mismatch_count = 0 and first_fail = 0 without it.
- start re-pulsed at t0+10 during a scan → ignored: single done at t0+25, and results are identical to the unperturbed run.
- reset asserted while idx = 3 → next cycle IDLE, selects 000, table_out = 0. A fresh start then completes normally with table_out = 8'h96.
- continuous = 1 with correct DUT → done pulses at t0+25, t0+50 and t0+75, with busy low only during the DONE cycles. match remains 1 throughout.

Source files
------------

// File: rtl/tabla_scanner.sv
// Truth-table scanner: steps {a,b,c} through 0..7, samples y_in after SETTLE cycles,
// and reports the captured table against EXPECTED. Define TABLA_MISMATCH_EN for mismatch_count/first_fail.
module tabla_scanner #(
    parameter int         SETTLE   = 2,
    parameter logic [7:0] EXPECTED = 8'h96
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       continuous,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match,
    output logic [3:0] mismatch_count,
    output logic [2:0] first_fail
);
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    state_t     state;
    logic [2:0] idx;
    logic [2:0] sel;
    logic [3:0] cnt;
    logic [7:0] work;
    logic [3:0] mc_nxt;
    logic [2:0] ff_nxt;

    assign {a_out, b_out, c_out} = sel;

`ifdef TABLA_MISMATCH_EN
    logic [7:0] diff;
    assign diff = work ^ EXPECTED;

    // Walk from the top so the lowest failing index wins.
    always_comb begin
        mc_nxt = 4'd0;
        ff_nxt = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            mc_nxt = mc_nxt + {3'd0, diff[i]};
            if (diff[i]) ff_nxt = 3'(i);
        end
    end
`else
    assign mc_nxt = 4'd0;
    assign ff_nxt = 3'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= 3'd0;
            sel            <= 3'd0;
            cnt            <= 4'd0;
            work           <= 8'h00;
            busy           <= 1'b0;
            done           <= 1'b0;
            table_out      <= 8'h00;
            match          <= 1'b0;
            mismatch_count <= 4'd0;
            first_fail     <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sel  <= 3'd0;
                    busy <= 1'b0;
                    if (start) begin
                        idx   <= 3'd0;
                        cnt   <= 4'd0;
                        work  <= 8'h00;
                        busy  <= 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(SETTLE - 1)) state <= SAMPLE;
                end
                SAMPLE: begin
                    work[idx] <= y_in;
                    if (idx == 3'd7) begin
                        sel   <= 3'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 3'd1;
                        sel   <= idx + 3'd1;
                        cnt   <= 4'd0;
                        state <= WAIT;
                    end
                end
                DONE: begin
                    table_out      <= work;
                    match          <= (work == EXPECTED);
                    mismatch_count <= mc_nxt;
                    first_fail     <= ff_nxt;
                    if (continuous) begin
                        idx   <= 3'd0;
                        cnt   <= 4'd0;
                        work  <= 8'h00;
                        busy  <= 1'b1;
                        state <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tabla_scanner.sv
// Randomized bench for tabla_scanner: the mux under test is a table chosen per scan,
// and every cycle is checked against a timing/result model derived from the scan schedule.
module tb_tabla_scanner;
    localparam int         S   = 2;
    localparam int         P   = 8 * (S + 1);
    localparam logic [7:0] EXP = 8'h96;

    logic       clk = 1'b0;
    logic       reset, start, continuous, y_in;
    logic       a_out, b_out, c_out, busy, done, match;
    logic [7:0] table_out;
    logic [3:0] mismatch_count;
    logic [2:0] first_fail;

    logic [7:0] cur_tbl;
    logic [7:0] r_tbl;
    logic       r_match;
    int         r_mc, r_ff;
    int         n_chk = 0, n_fail = 0;

    tabla_scanner #(.SETTLE(S), .EXPECTED(EXP)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .y_in(y_in),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .busy(busy), .done(done),
        .table_out(table_out), .match(match), .mismatch_count(mismatch_count),
        .first_fail(first_fail)
    );

    always #5 clk = ~clk;
    always_comb y_in = cur_tbl[{a_out, b_out, c_out}];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected results after a scan that captured tbl.
    task automatic set_result(input logic [7:0] tbl);
        logic [7:0] d;
        d       = tbl ^ EXP;
        r_tbl   = tbl;
        r_match = (tbl == EXP);
        r_mc    = 0;
        r_ff    = 0;
`ifdef TABLA_MISMATCH_EN
        r_mc = $countones(d);
        for (int i = 7; i >= 0; i--) if (d[i]) r_ff = i;
`endif
    endtask

    task automatic chk_results(input string tag);
        chk({tag, ".table"}, table_out, r_tbl);
        chk({tag, ".match"}, match, r_match);
        chk({tag, ".mcount"}, mismatch_count, r_mc);
        chk({tag, ".ffail"}, first_fail, r_ff);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".sel"}, {a_out, b_out, c_out}, 0);
        chk_results(tag);
    endtask

    function automatic logic [7:0] pick(input int mode);
        case (mode)
            0:       return 8'h96;
            1:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    // Runs nscans back-to-back scans; mode picks the mux behaviour; repulse pokes start mid-scan.
    task automatic scan(input int nscans, input int mode, input bit repulse);
        cur_tbl    = pick(mode);
        continuous = (nscans > 1);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int s = 0; s < nscans; s++) begin
            for (int n = 0; n <= P; n++) begin
                if (n < P) begin
                    chk("scan.busy", busy, 1);
                    chk("scan.done", done, 0);
                    chk("scan.sel", {a_out, b_out, c_out}, n / (S + 1));
                end else begin
                    chk("done.busy", busy, 0);
                    chk("done.done", done, 1);
                    chk("done.sel", {a_out, b_out, c_out}, 0);
                end
                if (n == 0 || n == P) chk_results("hold");
                if (repulse && s == 0 && n == 9)  start = 1'b1;
                if (repulse && s == 0 && n == 10) start = 1'b0;
                if (n == P) begin
                    set_result(cur_tbl);
                    cur_tbl = pick(mode);
                    if (s == nscans - 1) continuous = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        chk_idle("post");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; continuous = 1'b0; cur_tbl = 8'h96;
        set_result(8'h00);
        r_mc = 0; r_ff = 0; r_match = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_idle("reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_idle("noStart");

        scan(1, 0, 1'b0);                 // correct xor mux
        chk("xor.table", table_out, 8'h96);
        chk("xor.match", match, 1);
        scan(1, 1, 1'b0);                 // stuck-at-0
        scan(1, 0, 1'b1);                 // start re-pulsed mid-scan
        for (int k = 0; k < 4; k++) scan(1, 2, 1'b0);

        // Reset while idx = 3 discards everything.
        cur_tbl = 8'h96;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("mid.sel", {a_out, b_out, c_out}, 3);
        reset = 1'b1;
        @(posedge clk); #1;
        set_result(8'h00);
        r_mc = 0; r_ff = 0; r_match = 1'b0;
        chk_idle("midReset");
        // Reset and start together: reset wins.
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk_idle("rstStart");
        @(posedge clk); #1;
        chk_idle("rstStart2");

        scan(1, 0, 1'b0);                 // fresh scan after reset
        scan(3, 0, 1'b0);                 // continuous
        scan(3, 2, 1'b0);                 // continuous, random tables

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
